noc_tx_arbiter: RTL and testbench

NOC_TX_ARBITER -- requirements
Module: noc_tx_arbiter

---
 rtl/noc_tx_arbiter.sv | 163 ++++++++++++++++
 tb/tb_noc_tx_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_tx_arbiter.sv
// Round-robin arbiter that funnels NumReq requesters onto a single NoC transmit port.
// A granted payload is registered and presented until the NoC accepts it or the stall timeout aborts it.
module noc_tx_arbiter #(
    parameter int unsigned NumReq        = 4,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NumReq-1:0]            req_i,
    output logic [NumReq-1:0]            gnt_o,
    input  logic [NumReq-1:0][4:0]       dest_core_i,
    input  logic [NumReq-1:0][4:0]       addr_i,
    input  logic [NumReq-1:0][1:0]       len_i,
    input  logic [NumReq-1:0][31:0]      data_i,
    input  logic [NumReq-1:0][2:0][31:0] msg_i,
    output logic                         noc_req_o,
    input  logic                         noc_gnt_i,
    output logic                         output_valid_o,
    output logic [4:0]                   output_core_o,
    output logic [4:0]                   output_addr_o,
    output logic [1:0]                   len_o,
    output logic [31:0]                  output_data_o,
    output logic [31:0]                  msg1_data_o,
    output logic [31:0]                  msg2_data_o,
    output logic [31:0]                  msg3_data_o,
    output logic                         busy_o,
    output logic                         timeout_o,
    input  logic                         err_clr_i,
    output logic [15:0]                  sent_cnt_o
);

    localparam int unsigned IdxW = $clog2(NumReq);

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]   win_q, win_d;
    logic [IdxW-1:0]   win_c, rr_next;
    logic              win_found;
    logic              capture;
    logic              to_hit;
    logic [15:0]       stall_q, stall_d;
    logic [15:0]       sent_q, sent_d;
    logic              to_q, to_d;

    logic [4:0]        core_q, addr_q;
    logic [1:0]        len_q;
    logic [31:0]       data_q, msg1_q, msg2_q, msg3_q;

    // Two passes: first set bit at or above the pointer, otherwise wrap to the lowest set bit.
    always_comb begin
        win_c     = '0;
        win_found = 1'b0;
        for (int unsigned j = 0; j < NumReq; j++) begin
            if (!win_found && req_i[j] && (IdxW'(j) >= rr_ptr_q)) begin
                win_c     = IdxW'(j);
                win_found = 1'b1;
            end
        end
        for (int unsigned j = 0; j < NumReq; j++) begin
            if (!win_found && req_i[j]) begin
                win_c     = IdxW'(j);
                win_found = 1'b1;
            end
        end
    end

    assign rr_next = (win_q == IdxW'(NumReq - 1)) ? '0 : win_q + 1'b1;
    assign to_hit  = (TimeoutCycles != 0) && ((32'(stall_q) + 32'd1) >= TimeoutCycles);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        win_d    = win_q;
        stall_d  = stall_q;
        sent_d   = sent_q;
        to_d     = err_clr_i ? 1'b0 : to_q;
        gnt_o    = '0;
        capture  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Grant is combinational, so it must be masked while reset is held.
                if (win_found && !rst_i) begin
                    gnt_o[win_c] = 1'b1;
                    capture      = 1'b1;
                    win_d        = win_c;
                    stall_d      = '0;
                    state_d      = SEND;
                end
            end
            SEND: begin
                if (noc_gnt_i) begin
                    sent_d   = sent_q + 16'd1;
                    rr_ptr_d = rr_next;
                    state_d  = IDLE;
                end else if (to_hit) begin
                    to_d     = 1'b1;
                    rr_ptr_d = rr_next;
                    state_d  = IDLE;
                end else begin
                    stall_d = stall_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            win_q    <= '0;
            stall_q  <= '0;
            sent_q   <= '0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            win_q    <= win_d;
            stall_q  <= stall_d;
            sent_q   <= sent_d;
            to_q     <= to_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            core_q <= '0;
            addr_q <= '0;
            len_q  <= '0;
            data_q <= '0;
            msg1_q <= '0;
            msg2_q <= '0;
            msg3_q <= '0;
        end else if (capture) begin
            core_q <= dest_core_i[win_c];
            addr_q <= addr_i[win_c];
            len_q  <= len_i[win_c];
            data_q <= data_i[win_c];
            msg1_q <= (len_i[win_c] >= 2'd1) ? msg_i[win_c][0] : '0;
            msg2_q <= (len_i[win_c] >= 2'd2) ? msg_i[win_c][1] : '0;
            msg3_q <= (len_i[win_c] == 2'd3) ? msg_i[win_c][2] : '0;
        end
    end

    assign noc_req_o      = (state_q == SEND);
    assign output_valid_o = (state_q == SEND);
    assign busy_o         = (state_q != IDLE);
    assign timeout_o      = to_q;
    assign sent_cnt_o     = sent_q;
    assign output_core_o  = core_q;
    assign output_addr_o  = addr_q;
    assign len_o          = len_q;
    assign output_data_o  = data_q;
    assign msg1_data_o    = msg1_q;
    assign msg2_data_o    = msg2_q;
    assign msg3_data_o    = msg3_q;

endmodule

// File: tb/tb_noc_tx_arbiter.sv
// Directed and randomized bench for noc_tx_arbiter against a message-level reference model.
module tb_noc_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N-1:0]            req;
    logic [N-1:0]            gnt_o;
    logic [N-1:0][4:0]       dest;
    logic [N-1:0][4:0]       addr;
    logic [N-1:0][1:0]       len;
    logic [N-1:0][31:0]      data;
    logic [N-1:0][2:0][31:0] msg;
    logic                    noc_req_o, noc_gnt, output_valid_o;
    logic [4:0]              output_core_o, output_addr_o;
    logic [1:0]              len_o;
    logic [31:0]             output_data_o, msg1_data_o, msg2_data_o, msg3_data_o;
    logic                    busy_o, timeout_o, err_clr;
    logic [15:0]             sent_cnt_o;

    always #5 clk = ~clk;

    noc_tx_arbiter #(.NumReq(N), .TimeoutCycles(TO)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt_o),
        .dest_core_i(dest), .addr_i(addr), .len_i(len), .data_i(data), .msg_i(msg),
        .noc_req_o(noc_req_o), .noc_gnt_i(noc_gnt), .output_valid_o(output_valid_o),
        .output_core_o(output_core_o), .output_addr_o(output_addr_o), .len_o(len_o),
        .output_data_o(output_data_o), .msg1_data_o(msg1_data_o), .msg2_data_o(msg2_data_o),
        .msg3_data_o(msg3_data_o), .busy_o(busy_o), .timeout_o(timeout_o),
        .err_clr_i(err_clr), .sent_cnt_o(sent_cnt_o)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: one message in flight, how long it has waited, and the fairness pointer.
    bit          m_busy;
    int          m_ptr, m_win, m_wait;
    logic [15:0] m_sent;
    bit          m_to;
    logic [4:0]  m_core, m_addr;
    logic [1:0]  m_len;
    logic [31:0] m_data, m_m1, m_m2, m_m3;

    int  last_w;
    int  cyc = 0;
    int  obs_log[$];
    int  obs_cyc[$];
    int  obs_cnt[N];

    function automatic int pick(logic [N-1:0] r, int ptr);
        for (int k = 0; k < N; k++)
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_ptr = 0; m_win = 0; m_wait = 0; m_sent = '0; m_to = 0;
        m_core = '0; m_addr = '0; m_len = '0; m_data = '0; m_m1 = '0; m_m2 = '0; m_m3 = '0;
    endtask

    task automatic rand_payload(int i);
        dest[i] = 5'($urandom);
        addr[i] = 5'($urandom);
        len[i]  = 2'($urandom);
        data[i] = $urandom;
        for (int k = 0; k < 3; k++) msg[i][k] = $urandom;
    endtask

    task automatic cycle();
        int w;
        logic [N-1:0] eg;
        bit new_to;
        @(negedge clk);
        w  = m_busy ? -1 : pick(req, m_ptr);
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        chk("gnt_o", 32'(gnt_o), 32'(eg));
        for (int i = 0; i < N; i++)
            if (gnt_o[i]) begin
                obs_log.push_back(i);
                obs_cyc.push_back(cyc);
                obs_cnt[i]++;
            end
        chk("noc_req_o", 32'(noc_req_o), 32'(m_busy));
        chk("output_valid_o", 32'(output_valid_o), 32'(m_busy));
        chk("busy_o", 32'(busy_o), 32'(m_busy));
        chk("timeout_o", 32'(timeout_o), 32'(m_to));
        chk("sent_cnt_o", 32'(sent_cnt_o), 32'(m_sent));
        chk("output_core_o", 32'(output_core_o), 32'(m_core));
        chk("output_addr_o", 32'(output_addr_o), 32'(m_addr));
        chk("len_o", 32'(len_o), 32'(m_len));
        chk("output_data_o", output_data_o, m_data);
        chk("msg1_data_o", msg1_data_o, m_m1);
        chk("msg2_data_o", msg2_data_o, m_m2);
        chk("msg3_data_o", msg3_data_o, m_m3);
        last_w = w;
        @(posedge clk);
        cyc++;
        new_to = err_clr ? 1'b0 : m_to;
        if (!m_busy) begin
            if (w >= 0) begin
                m_core = dest[w]; m_addr = addr[w]; m_len = len[w]; m_data = data[w];
                m_m1 = (len[w] >= 2'd1) ? msg[w][0] : 32'h0;
                m_m2 = (len[w] >= 2'd2) ? msg[w][1] : 32'h0;
                m_m3 = (len[w] >= 2'd3) ? msg[w][2] : 32'h0;
                m_busy = 1; m_wait = 0; m_win = w;
            end
        end else if (noc_gnt) begin
            m_sent = m_sent + 16'd1;
            m_busy = 0;
            m_ptr  = (m_win + 1) % N;
        end else if (m_wait + 1 >= TO) begin
            new_to = 1'b1;
            m_busy = 0;
            m_ptr  = (m_win + 1) % N;
        end else begin
            m_wait++;
        end
        m_to = new_to;
        #1;
    endtask

    initial begin
        int hi;
        logic [15:0] snap;

        rst = 1'b1; req = '0; noc_gnt = 1'b0; err_clr = 1'b0;
        dest = '0; addr = '0; len = '0; data = '0; msg = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) cycle();

        // Single message, len 2, NoC accepts after three stall cycles.
        for (int i = 0; i < N; i++) obs_cnt[i] = 0;
        dest[0] = 5'h03; addr[0] = 5'h11; len[0] = 2'd2; data[0] = 32'hA5A5A5A5;
        msg[0][0] = 32'd1; msg[0][1] = 32'd2; msg[0][2] = 32'd3;
        req = 4'b0001;
        cycle();
        req = '0;
        repeat (3) cycle();
        noc_gnt = 1'b1;
        cycle();
        noc_gnt = 1'b0;
        cycle();
        chk("r32_gnt0_pulses", 32'(obs_cnt[0]), 32'd1);
        chk("r32_msg1", msg1_data_o, 32'd1);
        chk("r32_msg2", msg2_data_o, 32'd2);
        chk("r32_msg3", msg3_data_o, 32'd0);
        chk("r32_sent", 32'(sent_cnt_o), 32'd1);

        // Reset asserted mid-SEND with a request still pending.
        dest[2] = 5'h1F; addr[2] = 5'h0A; len[2] = 2'd3; data[2] = 32'hDEADBEEF;
        msg[2][0] = 32'h11; msg[2][1] = 32'h22; msg[2][2] = 32'h33;
        req = 4'b0100;
        cycle();
        chk("r36_pre_busy", 32'(busy_o), 32'd1);
        #3 rst = 1'b1;
        #1;
        model_reset();
        chk("r36_noc_req", 32'(noc_req_o), 32'd0);
        chk("r36_valid", 32'(output_valid_o), 32'd0);
        chk("r36_gnt", 32'(gnt_o), 32'd0);
        chk("r36_busy", 32'(busy_o), 32'd0);
        chk("r36_sent", 32'(sent_cnt_o), 32'd0);
        chk("r36_data", output_data_o, 32'd0);
        chk("r36_core", 32'(output_core_o), 32'd0);
        chk("r36_msg1", msg1_data_o, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // All four requesting, NoC always ready: strict rotation, one message per two cycles.
        for (int i = 0; i < N; i++) rand_payload(i);
        req = 4'b1111;
        noc_gnt = 1'b1;
        obs_log.delete();
        obs_cyc.delete();
        repeat (10) cycle();
        chk("r33_ngrants", 32'(obs_log.size()), 32'd5);
        for (int k = 0; k < 5; k++)
            if (obs_log.size() > k) chk($sformatf("r33_order%0d", k), 32'(obs_log[k]), 32'(k % N));
        for (int k = 0; k < 4; k++)
            if (obs_cyc.size() > k + 1) chk($sformatf("r33_gap%0d", k), 32'(obs_cyc[k+1] - obs_cyc[k]), 32'd2);
        req = '0;
        repeat (2) cycle();
        noc_gnt = 1'b0;

        // Timeout: NoC never accepts.
        snap = m_sent;
        rand_payload(1);
        req = 4'b0010;
        cycle();
        req = '0;
        hi = 0;
        for (int k = 0; k < 8; k++) begin
            if (noc_req_o) hi++;
            cycle();
        end
        chk("r34_req_cycles", 32'(hi), 32'd4);
        chk("r34_timeout", 32'(timeout_o), 32'd1);
        chk("r34_sent", 32'(sent_cnt_o), 32'(snap));
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        cycle();
        chk("r34_cleared", 32'(timeout_o), 32'd0);

        // Grant arrives on exactly the timeout cycle.
        snap = m_sent;
        rand_payload(2);
        req = 4'b0100;
        cycle();
        req = '0;
        repeat (3) cycle();
        noc_gnt = 1'b1;
        cycle();
        noc_gnt = 1'b0;
        cycle();
        chk("r35_sent", 32'(sent_cnt_o), 32'(snap + 16'd1));
        chk("r35_timeout", 32'(timeout_o), 32'd0);

        // Randomized traffic with random NoC back-pressure and error clears.
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++)
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    rand_payload(i);
                    req[i] = 1'b1;
                end
            noc_gnt = ($urandom_range(0, 2) == 0);
            err_clr = ($urandom_range(0, 15) == 0);
            cycle();
            if (last_w >= 0) req[last_w] = 1'b0;
        end
        req = '0; err_clr = 1'b0; noc_gnt = 1'b1;
        repeat (2) cycle();

        // Counter wrap from 0xFFFF.
        force dut.sent_q = 16'hFFFF;
        #1;
        release dut.sent_q;
        m_sent = 16'hFFFF;
        rand_payload(3);
        req = 4'b1000;
        cycle();
        req = '0;
        cycle();
        noc_gnt = 1'b0;
        cycle();
        chk("r37_wrap", 32'(sent_cnt_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
